conv_window_buffer: RTL and testbench

Streaming sliding-window generator that sits directly upstream of the NxN dot-product stage. It accepts one BitSize-bit pixel per cycle in raster order and buffers N-1 image rows in line buffers. For every fully-inside NxN neighbourhood (no padding, stride 1), it emits the window packed exactly as the dot stage's in_data bus. Output is a single registered stage with a valid/ready handshake.

---
 rtl/conv_window_buffer.sv | 137 +++++++++++++
 tb/tb_conv_window_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// Streaming NxN sliding-window generator: N-1 line buffers feed a shift-register
// window, which is published through one registered valid/ready output stage.
module conv_window_buffer #(
  parameter int N           = 3,
  parameter int BitSize     = 8,
  parameter int ImageWidth  = 28,
  parameter int ImageHeight = 28
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BitSize-1:0]             in_pixel,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [BitSize*N*N-1:0]         out_window,
  output logic [$clog2(ImageHeight)-1:0] out_row,
  output logic [$clog2(ImageWidth)-1:0]  out_col,
  output logic                           frame_done
);
  localparam int RW = $clog2(ImageHeight);
  localparam int CW = $clog2(ImageWidth);
  localparam int WW = BitSize * N * N;
  localparam logic [CW-1:0] ColLast  = CW'(ImageWidth - 1);
  localparam logic [RW-1:0] RowLast  = RW'(ImageHeight - 1);
  localparam logic [CW-1:0] ColFirst = CW'(N - 1);
  localparam logic [RW-1:0] RowFirst = RW'(N - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] win_q, win_d, win_shift;
  logic          out_valid_q, out_valid_d;
  logic [WW-1:0] out_window_q, out_window_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, emit;

  logic [BitSize-1:0] lb_mem [N-1][ImageWidth];
  logic [BitSize-1:0] lb_rd  [N-1];
  logic [BitSize-1:0] lb_wr  [N-1];

  assign in_ready = !out_valid_q || out_ready;

  // Line buffer k holds image row (row - (N-1) + k) at each column; reads are
  // asynchronous so the pre-write contents form the incoming window column.
  for (genvar gi = 0; gi < N - 1; gi++) begin : g_lb
    assign lb_rd[gi] = lb_mem[gi][col_q];
    if (gi < N - 2) begin : g_chain
      assign lb_wr[gi] = lb_rd[gi+1];
    end else begin : g_tail
      assign lb_wr[gi] = in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N - 1; k++) begin
        lb_mem[k][col_q] <= lb_wr[k];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_wrow
    for (genvar gj = 0; gj < N; gj++) begin : g_wcol
      localparam int Idx = gi * N + gj;
      if (gj < N - 1) begin : g_shift
        assign win_shift[BitSize*Idx +: BitSize] = win_q[BitSize*(Idx+1) +: BitSize];
      end else if (gi < N - 1) begin : g_from_lb
        assign win_shift[BitSize*Idx +: BitSize] = lb_rd[gi];
      end else begin : g_from_in
        assign win_shift[BitSize*Idx +: BitSize] = in_pixel;
      end
    end
  end

  always_comb begin
    accept       = in_valid && in_ready;
    emit         = accept && (row_q >= RowFirst) && (col_q >= ColFirst);
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_window_d = out_window_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = accept && (row_q == RowLast) && (col_q == ColLast);

    if (accept) begin
      win_d = win_shift;
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A new window reloads the register even while the old one drains.
    if (emit) begin
      out_valid_d  = 1'b1;
      out_window_d = win_shift;
      out_row_d    = row_q;
      out_col_d    = col_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: image-array reference model with a per-cycle
// compare process, directed scenarios with literal windows, and random traffic.
`timescale 1ns/1ps
module tb_conv_window_buffer;
  localparam int N  = 3;
  localparam int B  = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WW = B * N * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [B-1:0]  in_pixel = '0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [WW-1:0] out_window;
  logic [1:0]    out_row;
  logic [2:0]    out_col;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_buffer #(.N(N), .BitSize(B), .ImageWidth(W), .ImageHeight(H)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_ready(out_ready), .out_valid(out_valid), .out_window(out_window),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic logic [WW-1:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [WW-1:0] v;
    v = {B'(e8), B'(e7), B'(e6), B'(e5), B'(e4), B'(e3), B'(e2), B'(e1), B'(e0)};
    return v;
  endfunction

  // Reference model: the image as written so far, and windows awaiting transfer.
  typedef struct { logic [WW-1:0] w; int r; int c; } win_t;
  win_t exp_q[$];
  win_t head;
  int   img [H][W];
  int   m_row = 0, m_col = 0, acc_count = 0;
  bit   exp_fd = 0;

  logic [WW-1:0] log_w [64];
  int   log_r [64], log_c [64], log_acc [64];
  int   log_n = 0;
  int   fd_seen = 0;
  bit   fd_ok = 0;
  bit   rnd_ready = 0;
  logic [WW-1:0] s1_w [6];

  function automatic logic [WW-1:0] model_window(input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < N * N; i++)
      v[B*i +: B] = B'(img[r - N + 1 + i / N][c - N + 1 + i % N]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_valid", WW'(out_valid), '0);
      chk("rst_out_window", out_window, '0);
      chk("rst_out_row", WW'(out_row), '0);
      chk("rst_out_col", WW'(out_col), '0);
      chk("rst_frame_done", WW'(frame_done), '0);
      exp_q.delete();
      m_row = 0; m_col = 0; acc_count = 0; exp_fd = 0;
    end else begin
      chk("frame_done", WW'(frame_done), WW'(exp_fd));
      chk("in_ready", WW'(in_ready), WW'(!out_valid || out_ready));
      if (frame_done) begin
        fd_seen++;
        fd_ok = out_valid && (out_row == 2'(H - 1)) && (out_col == 3'(W - 1));
      end
      if (exp_q.size() == 0) begin
        chk("out_valid_idle", WW'(out_valid), '0);
      end else begin
        head = exp_q[0];
        chk("out_valid", WW'(out_valid), WW'(1));
        if (out_valid) begin
          chk("out_window", out_window, head.w);
          chki("out_row", int'(out_row), head.r);
          chki("out_col", int'(out_col), head.c);
          if (out_ready) begin
            if (log_n < 64) begin
              log_w[log_n] = out_window; log_r[log_n] = int'(out_row);
              log_c[log_n] = int'(out_col); log_acc[log_n] = acc_count;
              log_n++;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      exp_fd = 0;
      if (in_valid && in_ready) begin
        img[m_row][m_col] = int'(in_pixel);
        acc_count++;
        if (m_row >= N - 1 && m_col >= N - 1)
          exp_q.push_back('{w: model_window(m_row, m_col), r: m_row, c: m_col});
        exp_fd = (m_row == H - 1) && (m_col == W - 1);
        m_col++;
        if (m_col == W) begin
          m_col = 0;
          m_row++;
          if (m_row == H) m_row = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_pixel(input int v, input bit gap);
    bit acc;
    int budget;
    acc = 0; budget = 0;
    in_valid = 1'b1; in_pixel = B'(v);
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      budget++;
      if (!acc && budget > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", budget);
        $fatal(1, "input stalled");
      end
    end
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // gap_mode: 0 = valid held, 1 = valid every other cycle, 2 = random gaps
  task automatic send_frame(input int base, input int gap_mode, input bit rnd_px);
    for (int i = 0; i < W * H; i++) begin
      send_pixel(rnd_px ? int'($urandom_range(0, 255)) : base + i,
                 gap_mode == 1 ? 1'b1 : (gap_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int exp_rows [6] = '{2, 2, 2, 3, 3, 3};
  int exp_cols [6] = '{2, 3, 4, 2, 3, 4};

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Raster frame 0..19, no backpressure
    log_n = 0; fd_seen = 0;
    send_frame(0, 0, 0);
    idle(4);
    chki("s1_count", log_n, 6);
    for (int k = 0; k < 6; k++) begin
      chki("s1_row", log_r[k], exp_rows[k]);
      chki("s1_col", log_c[k], exp_cols[k]);
      s1_w[k] = log_w[k];
    end
    chk("s1_first", log_w[0], pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chk("s1_last", log_w[5], pk(7, 8, 9, 12, 13, 14, 17, 18, 19));
    chki("s1_fd_count", fd_seen, 1);
    chki("s1_fd_with_last", int'(fd_ok), 1);

    // Backpressure right after the first window
    log_n = 0;
    fork
      send_frame(0, 0, 0);
      begin : stall
        int t;
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        chk("s2_first_valid", WW'(out_valid), WW'(1));
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("s2_hold_in_ready", WW'(in_ready), '0);
          chk("s2_hold_window", out_window, pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(4);
    chki("s2_count", log_n, 6);
    chk("s2_w0", log_w[0], pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chk("s2_w1", log_w[1], pk(1, 2, 3, 6, 7, 8, 11, 12, 13));
    chki("s2_w1_col", log_c[1], 3);

    // Valid every other cycle
    log_n = 0;
    send_frame(0, 1, 0);
    idle(4);
    chki("s3_count", log_n, 6);
    for (int k = 0; k < 6; k++) chk("s3_same_as_s1", log_w[k], s1_w[k]);

    // Back-to-back frames
    log_n = 0;
    send_frame(0, 0, 0);
    send_frame(100, 0, 0);
    idle(4);
    chki("s4_count", log_n, 12);
    chk("s4_f2_first", log_w[6], pk(100, 101, 102, 105, 106, 107, 110, 111, 112));
    chki("s4_f2_first_row", log_r[6], 2);
    chki("s4_f2_first_col", log_c[6], 2);

    // Reset after pixel 8, then a fresh frame
    log_n = 0;
    for (int i = 0; i < 9; i++) send_pixel(i, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    log_n = 0;
    send_frame(0, 0, 0);
    idle(4);
    chki("s5_count", log_n, 6);
    chk("s5_first", log_w[0], pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chki("s5_first_after_13", log_acc[0], 13);

    // Random pixels, random gaps, random backpressure
    log_n = 0;
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(0, 2, 1);
    rnd_ready = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(6);
    chki("s6_count", log_n, 18);
    chki("s6_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end
endmodule
